// File: rtl/pre_if_stage_pkg.sv
// Shared definitions for the pre-IF fetch stage.
// Holds the bus widths, the default reset fetch address, the 2-bit state
// encoding of the request sequencer and a small PC helper function.
package pre_if_stage_pkg;

    localparam int          BR_BUS_WD           = 33;
    localparam int          PFS_TO_FS_BUS_WD    = 33;
    localparam logic [31:0] PFS_RESET_PC_DEFAULT = 32'h1c000000;

    typedef enum logic [1:0] {
        PFS_IDLE = 2'd0,
        PFS_REQ  = 2'd1,
        PFS_HOLD = 2'd2
    } pfs_state_e;

    // Sequential fetch address; modulo 2^32 so 32'hfffffffc wraps to 0.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pre_if_stage.sv
// Pre-IF stage: generates the fetch PC, issues requests on the SRAM-like
// instruction bus and hands each accepted PC to IF via valid/allowin.
// Redirects (exception > ertn > branch) are buffered while a fetch is in
// flight, and the in-flight fetch is marked cancelled so IF discards it.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   fs_allowin             IF can take an entry this cycle
//   br_bus                 {br_taken, br_target} from ID
//   wb_ex, ex_entry        exception flush and its entry address
//   ertn_flush, era        ertn flush and its return address
//   pfs_to_fs_valid        entry offered to IF
//   pfs_to_fs_bus          {cancel, pc} offered to IF (zero when not valid)
//   inst_sram_*            instruction bus request side (read-only use)
//   inst_sram_addr_ok      request accepted this cycle
module pre_if_stage
    import pre_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PFS_RESET_PC_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fs_allowin,
    input  logic [BR_BUS_WD-1:0]        br_bus,
    input  logic                        wb_ex,
    input  logic [31:0]                 ex_entry,
    input  logic                        ertn_flush,
    input  logic [31:0]                 era,
    output logic                        pfs_to_fs_valid,
    output logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus,
    output logic                        inst_sram_req,
    output logic                        inst_sram_wr,
    output logic [1:0]                  inst_sram_size,
    output logic [3:0]                  inst_sram_wstrb,
    output logic [31:0]                 inst_sram_addr,
    output logic [31:0]                 inst_sram_wdata,
    input  logic                        inst_sram_addr_ok
);

    pfs_state_e  state_r;
    logic [31:0] req_pc_r;
    logic        redir_valid_r;
    logic [31:0] redir_pc_r;
    logic        stale_r;

    logic        br_taken_s;
    logic [31:0] br_target_s;
    logic        redir_now_s;
    logic [31:0] redir_tgt_s;
    logic        valid_s;
    logic        handover_s;
    logic [31:0] next_pc_s;

    // Select this cycle's redirect source by priority: exception, ertn, branch.
    always_comb begin
        br_taken_s  = br_bus[32];
        br_target_s = br_bus[31:0];
        redir_now_s = wb_ex | ertn_flush | br_taken_s;
        if (wb_ex) begin
            redir_tgt_s = ex_entry;
        end else if (ertn_flush) begin
            redir_tgt_s = era;
        end else begin
            redir_tgt_s = br_target_s;
        end
    end

    // Offer an entry to IF: straight from addr_ok in REQ, held in HOLD.
    always_comb begin
        case (state_r)
            PFS_REQ:  valid_s = inst_sram_addr_ok;
            PFS_HOLD: valid_s = 1'b1;
            default:  valid_s = 1'b0;
        endcase
        handover_s = valid_s & fs_allowin;
    end

    // Next fetch PC after a handover: a same-cycle redirect beats a
    // buffered one, which beats sequential flow.
    always_comb begin
        if (redir_now_s) begin
            next_pc_s = redir_tgt_s;
        end else if (redir_valid_r) begin
            next_pc_s = redir_pc_r;
        end else begin
            next_pc_s = pc_plus4(req_pc_r);
        end
    end

    // Request sequencer and redirect buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= PFS_IDLE;
            req_pc_r      <= RESET_PC;
            redir_valid_r <= 1'b0;
            redir_pc_r    <= 32'd0;
            stale_r       <= 1'b0;
        end else begin
            case (state_r)
                PFS_IDLE: begin
                    state_r <= PFS_REQ;
                    // Nothing issued yet, so a redirect simply retargets.
                    if (redir_now_s) begin
                        req_pc_r <= redir_tgt_s;
                    end
                end
                PFS_REQ, PFS_HOLD: begin
                    if (handover_s) begin
                        state_r       <= PFS_REQ;
                        req_pc_r      <= next_pc_s;
                        redir_valid_r <= 1'b0;
                        stale_r       <= 1'b0;
                    end else begin
                        // The fetch in flight is now on the wrong path.
                        if (redir_now_s) begin
                            redir_valid_r <= 1'b1;
                            redir_pc_r    <= redir_tgt_s;
                            stale_r       <= 1'b1;
                        end
                        if (state_r == PFS_REQ && inst_sram_addr_ok) begin
                            state_r <= PFS_HOLD;
                        end
                    end
                end
                default: begin
                    state_r <= PFS_IDLE;
                end
            endcase
        end
    end

    assign inst_sram_req   = (state_r == PFS_REQ);
    assign inst_sram_addr  = req_pc_r;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'd0;

    assign pfs_to_fs_valid = valid_s;
    assign pfs_to_fs_bus   = valid_s ? {stale_r | redir_now_s, req_pc_r} : 33'd0;

endmodule

// File: tb/tb_pre_if_stage.sv
module tb_pre_if_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fs_allowin = 1'b0;
    logic [32:0] br_bus = 33'd0;
    logic        wb_ex = 1'b0;
    logic [31:0] ex_entry = 32'd0;
    logic        ertn_flush = 1'b0;
    logic [31:0] era = 32'd0;
    logic        pfs_to_fs_valid;
    logic [32:0] pfs_to_fs_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok = 1'b0;

    int compared = 0;
    int mismatched = 0;

    pre_if_stage dut (
        .clk(clk), .reset(reset), .fs_allowin(fs_allowin), .br_bus(br_bus),
        .wb_ex(wb_ex), .ex_entry(ex_entry), .ertn_flush(ertn_flush), .era(era),
        .pfs_to_fs_valid(pfs_to_fs_valid), .pfs_to_fs_bus(pfs_to_fs_bus),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok)
    );

    always #5 clk = ~clk;

    // Reference model: where the current fetch is in its life (0 nothing
    // issued, 1 waiting for bus accept, 2 accepted and waiting for IF),
    // its PC, whether it is known to be wrong-path, and pending redirects.
    int          m_phase = 0;
    logic [31:0] m_pc = 32'h1c000000;
    logic        m_cancel = 1'b0;
    logic [31:0] m_redir_q[$];

    logic [32:0] last_bus;
    logic        last_valid;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst_v, input logic ao, input logic fa,
                        input logic brt, input logic [31:0] brtg,
                        input logic wbe, input logic [31:0] exe,
                        input logic ertn_v, input logic [31:0] era_v);
        logic        redir;
        logic [31:0] tgt;
        logic        e_valid;
        logic [32:0] e_bus;
        @(negedge clk);
        reset = rst_v; inst_sram_addr_ok = ao; fs_allowin = fa;
        br_bus = {brt, brtg}; wb_ex = wbe; ex_entry = exe;
        ertn_flush = ertn_v; era = era_v;
        if (rst_v) begin
            m_phase = 0; m_pc = 32'h1c000000; m_cancel = 1'b0; m_redir_q.delete();
        end
        #1;
        redir = wbe | ertn_v | brt;
        tgt = wbe ? exe : (ertn_v ? era_v : brtg);
        e_valid = (m_phase == 1) ? ao : (m_phase == 2);
        e_bus = e_valid ? {m_cancel | redir, m_pc} : 33'd0;
        chk("req",   {32'd0, inst_sram_req}, {32'd0, m_phase == 1});
        chk("valid", {32'd0, pfs_to_fs_valid}, {32'd0, e_valid});
        chk("bus",   pfs_to_fs_bus, e_bus);
        chk("addr",  {1'b0, inst_sram_addr}, {1'b0, m_pc});
        chk("tied",  {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
                     {1'b0, 2'b10, 4'b0000, 32'd0} );
        last_bus = pfs_to_fs_bus;
        last_valid = pfs_to_fs_valid;
        @(posedge clk);
        if (!rst_v) begin
            if (m_phase == 0) begin
                m_phase = 1;
                if (redir) m_pc = tgt;
            end else if (e_valid && fa) begin
                if (redir) m_pc = tgt;
                else if (m_redir_q.size() > 0) m_pc = m_redir_q[$];
                else m_pc = m_pc + 32'd4;
                m_redir_q.delete();
                m_cancel = 1'b0;
                m_phase = 1;
            end else begin
                if (redir) begin
                    m_redir_q.push_back(tgt);
                    m_cancel = 1'b1;
                end
                if (m_phase == 1 && ao) m_phase = 2;
            end
        end
    endtask

    // Plain sequential cycle with no redirect.
    task automatic seq(input logic ao, input logic fa);
        step(1'b0, ao, fa, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic chk_addr_after(input string tag, input logic [31:0] exp);
        #1;
        chk(tag, {1'b0, inst_sram_addr}, {1'b0, exp});
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] t1, t2, t3;
        // Reset held
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        // Release: IDLE cycle, then sequential handovers
        seq(1'b1, 1'b1);
        chk("idle_no_valid", {32'd0, last_valid}, 33'd0);
        for (int i = 0; i < 4; i++) begin
            seq(1'b1, 1'b1);
            chk("seq_bus", last_bus, {1'b0, 32'h1c000000 + 32'(4 * i)});
        end
        // Accept at 1c000010 while IF stalls
        seq(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            seq(1'b0, 1'b0);
            chk("hold_bus", last_bus, {1'b0, 32'h1c000010});
        end
        seq(1'b0, 1'b1);
        chk_addr_after("after_hold", 32'h1c000014);
        for (int i = 0; i < 3; i++) seq(1'b1, 1'b1);
        // addr_ok withheld at 1c000020; branch in second waiting cycle
        seq(1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h1c000100, 1'b0, 32'd0, 1'b0, 32'd0);
        seq(1'b0, 1'b1);
        seq(1'b0, 1'b1);
        chk_addr_after("stable_addr", 32'h1c000020);
        seq(1'b1, 1'b1);
        chk("br_cancel_bus", last_bus, {1'b1, 32'h1c000020});
        chk_addr_after("br_target", 32'h1c000100);
        // Exception and branch together during handover
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h1c000200, 1'b1, 32'h1c008000, 1'b0, 32'd0);
        chk("ex_bus", last_bus, {1'b1, 32'h1c000100});
        chk_addr_after("ex_target", 32'h1c008000);
        // HOLD: branch then ertn, newest wins
        seq(1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h1c000300, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h1c000400);
        seq(1'b0, 1'b1);
        chk("ertn_bus", last_bus, {1'b1, 32'h1c008000});
        chk_addr_after("ertn_target", 32'h1c000400);
        // Reset asserted while in HOLD: outputs drop asynchronously
        seq(1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("async_rst_valid", {32'd0, last_valid}, 33'd0);
        seq(1'b1, 1'b1);
        seq(1'b1, 1'b1);
        chk("restart_bus", last_bus, {1'b0, 32'h1c000000});
        // Redirect in IDLE to the top of memory, then wrap
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hfffffffc, 1'b0, 32'd0, 1'b0, 32'd0);
        chk_addr_after("idle_redir", 32'hfffffffc);
        seq(1'b1, 1'b1);
        chk("wrap_bus", last_bus, {1'b0, 32'hfffffffc});
        chk_addr_after("wrap_addr", 32'h00000000);
        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            t1 = $urandom; t1[1:0] = 2'b00;
            t2 = $urandom; t2[1:0] = 2'b00;
            t3 = (r[20:18] == 3'd0) ? 32'hfffffffc : {t1[31:4], 4'h8};
            step(r[9:0] == 10'd0 || r[7:0] == 8'd1,
                 r[1:0] != 2'b00, r[3:2] != 2'b00,
                 r[6:4] == 3'd0, t3,
                 r[11:8] == 4'd0, t1,
                 r[15:12] == 4'd0, t2);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pre_if_stage.md
Name: pre_if_stage

Overview:
- Pre-IF stage of the 5-stage LoongArch pipeline, directly upstream of the IF stage.
- Generates the fetch PC and issues requests on an SRAM-like instruction bus (req/addr_ok).
- Hands each accepted request's PC to IF through a valid/allowin handshake.
- Absorbs branch, exception and ertn redirects by buffering the target; tags already-issued fetches as cancelled so IF discards their instruction.

Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset.
- BR_BUS_WD, 33, width of br_bus, packed as {br_taken, br_target}.
- PFS_TO_FS_BUS_WD, 33, width of pfs_to_fs_bus, packed as {cancel, pc}.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fs_allowin  in  1  IF stage can accept an entry this cycle.
- br_bus  in  33  {br_taken, br_target} from ID.
- wb_ex  in  1  exception flush from WB.
- ex_entry  in  32  exception entry address, valid when wb_ex=1.
- ertn_flush  in  1  ertn flush from WB.
- era  in  32  return address, valid when ertn_flush=1.
- pfs_to_fs_valid  out  1  entry offered to IF.
- pfs_to_fs_bus  out  33  {cancel, pc}.
- inst_sram_req  out  1  fetch request.
- inst_sram_wr  out  1  tied 0.
- inst_sram_size  out  2  tied 2'b10.
- inst_sram_wstrb  out  4  tied 0.
- inst_sram_addr  out  32  fetch address, equal to req_pc.
- inst_sram_wdata  out  32  tied 0.
- inst_sram_addr_ok  in  1  request accepted this cycle.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, named clk and reset.
- Reset values: state=IDLE, req_pc=RESET_PC, redir_valid=0, redir_pc=0, stale=0. Consequently inst_sram_req=0, pfs_to_fs_valid=0, pfs_to_fs_bus=0 while reset is asserted and in the first cycle after it.
- Redirect source, single cycle, priority wb_ex > ertn_flush > br_taken:
  - redir_now = wb_ex | ertn_flush | br_taken.
  - redir_tgt = wb_ex ? ex_entry : ertn_flush ? era : br_target.
- State IDLE: req=0, valid=0; next state is REQ unconditionally.
- State REQ: inst_sram_req=1, addr=req_pc.
  - addr/req_pc stay stable until addr_ok; a request is never withdrawn.
  - pfs_to_fs_valid = inst_sram_addr_ok (combinational pass-through).
  - addr_ok & fs_allowin: handover this cycle; stay in REQ with the new req_pc.
  - addr_ok & !fs_allowin: go to HOLD.
  - no addr_ok: stay in REQ.
- State HOLD: req=0, pfs_to_fs_valid=1. fs_allowin: handover and go to REQ; otherwise stay in HOLD.
- Handover (valid & fs_allowin):
  - bus = {stale | redir_now, req_pc}.
  - req_pc <= redir_now ? redir_tgt : redir_valid ? redir_pc : req_pc+4.
  - redir_valid <= 0, stale <= 0.
- Redirect with no handover (REQ or HOLD):
  - redir_valid <= 1, redir_pc <= redir_tgt. The newest redirect overwrites an older buffered one.
  - stale <= 1.
- Redirect in IDLE: req_pc <= redir_tgt directly; stale unchanged.
- Arithmetic: req_pc+4 is a 32-bit modulo add; 32'hfffffffc wraps to 0.
- At most one request is outstanding at the address phase. Data return is IF's concern; this block never sees data_ok.
- Reset mid-operation: all state clears immediately. An accepted-but-unhanded entry is lost; IF is reset together with this block.

Decomposition:
- Shared header mycpu.h: BR_BUS_WD, PFS_TO_FS_BUS_WD, RESET_PC default, state encodings PFS_IDLE/PFS_REQ/PFS_HOLD (2-bit).
- No sub-module; a single flat module of roughly 150 lines.

Test Plan:
- Reset release, addr_ok=1, fs_allowin=1 -> req rises 1 cycle after reset deasserts; addrs 1c000000, 1c000004, 1c000008 handed with cancel=0 on consecutive cycles.
- addr_ok=1 at pc 1c000010 while fs_allowin=0 for 3 cycles -> state HOLD, req=0, valid held with bus {0,1c000010}; fs_allowin=1 -> next req addr 1c000014.
- addr_ok held 0 for 4 cycles at pc 1c000020, br_bus={1,1c000100} pulsed in cycle 2 -> addr stays 1c000020; on accept, handed with cancel=1; next req addr 1c000100.
- Same cycle: wb_ex=1, ex_entry=1c008000, br_taken=1, br_target=1c000200, handover occurring -> handed cancel=1; next addr 1c008000.
- In HOLD, br to 1c000300 then ertn_flush with era=1c000400 next cycle -> handed cancel=1; next addr 1c000400.
- Assert reset while in HOLD -> req and valid drop immediately (asynchronous); after release, first addr 1c000000.
